// File: rtl/decoder_4to16.sv
// decoder_4to16 -- registered 4-to-16 one-hot decoder.
//
// Turns a 4-bit binary index into a one-hot select word for per-channel
// enable fan-out. The output is registered. While the decoder is disabled
// the output is forced to zero, so a stale decode is never held.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   rst    in   1   synchronous active-high reset
//   en     in   1   decode enable for this cycle's sample
//   in     in   4   binary index 0..15
//   out    out  16  one-hot decode of the sampled index, or zero
//   valid  out  1   high when out holds the decode of an enabled sample
//
// Build option:
//   DECODER_4TO16_INPUT_REG_EN  adds an input register for en/in ahead of
//                               the decode. Latency becomes 2 instead of 1.
//                               Both stages are cleared by rst.

module decoder_4to16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  in,
  output logic [15:0] out,
  output logic        valid
);

  // Sample that feeds the decode: either the raw ports or the input stage.
  logic       en_s;
  logic [3:0] in_s;

`ifdef DECODER_4TO16_INPUT_REG_EN
  logic       en_q;
  logic [3:0] in_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q <= 1'b0;
      in_q <= '0;
    end else begin
      en_q <= en;
      in_q <= in;
    end
  end

  assign en_s = en_q;
  assign in_s = in_q;
`else
  assign en_s = en;
  assign in_s = in;
`endif

  // One compare per output line. Each line matches exactly one index value,
  // so the word is one-hot by construction.
  logic [15:0] dec;

  for (genvar k = 0; k < 16; k++) begin : g_dec
    assign dec[k] = (in_s == 4'(k));
  end

  logic [15:0] out_d, out_q;
  logic        valid_d, valid_q;

  // Disabled samples produce an all-zero word rather than holding the last one.
  always_comb begin
    out_d   = en_s ? dec : '0;
    valid_d = en_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_decoder_4to16.sv
// Directed bench for decoder_4to16. Each vector carries a hand-computed
// expected word for its own index. The bench applies a vector every cycle.
// After each edge it derives what the outputs must be from the vector that
// entered LAT edges earlier, and from any reset inside that window.
module tb_decoder_4to16;

`ifdef DECODER_4TO16_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  in;
  logic [15:0] out;
  logic        valid;

  decoder_4to16 dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .in    (in),
    .out   (out),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Hand-written one-hot table, index -> expected word.
  logic [15:0] oh [16] = '{
    16'h0001, 16'h0002, 16'h0004, 16'h0008,
    16'h0010, 16'h0020, 16'h0040, 16'h0080,
    16'h0100, 16'h0200, 16'h0400, 16'h0800,
    16'h1000, 16'h2000, 16'h4000, 16'h8000
  };

  // Vector queues: rst, en, in, expected word when this sample is decoded.
  bit          v_r [$];
  bit          v_e [$];
  logic [3:0]  v_i [$];
  logic [15:0] v_x [$];

  task automatic add(input bit r, input bit e, input logic [3:0] i, input logic [15:0] x);
    v_r.push_back(r);
    v_e.push_back(e);
    v_i.push_back(i);
    v_x.push_back(x);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    in  = '0;

    // Reset held for 2 cycles with en=1, in=10.
    add(1, 1, 4'd10, 16'h0400);
    add(1, 1, 4'd10, 16'h0400);
    // First decode after release.
    add(0, 1, 4'd10, 16'h0400);
    // Full sweep 0..15.
    for (int k = 0; k < 16; k++) add(0, 1, 4'(k), oh[k]);
    // Boundary: 15 then 0 back-to-back.
    add(0, 1, 4'd15, 16'h8000);
    add(0, 1, 4'd0,  16'h0001);
    // Enable gating with in=3.
    add(0, 1, 4'd3, 16'h0008);
    add(0, 0, 4'd3, 16'h0008);
    add(0, 1, 4'd3, 16'h0008);
    // Sweep with a one-cycle reset at in=7.
    for (int k = 0; k < 16; k++) add((k == 7), 1, 4'(k), oh[k]);
    // Latency: idle, one-cycle pulse at in=9, idle.
    add(0, 0, 4'd9, 16'h0200);
    add(0, 0, 4'd9, 16'h0200);
    add(0, 1, 4'd9, 16'h0200);
    add(0, 0, 4'd9, 16'h0200);
    add(0, 0, 4'd9, 16'h0200);
    add(0, 0, 4'd9, 16'h0200);

    for (int t = 0; t < v_r.size(); t++) begin
      logic [15:0] eo;
      logic        ev;
      bit          rwin;
      int          s;
      @(negedge clk);
      rst = v_r[t];
      en  = v_e[t];
      in  = v_i[t];
      @(posedge clk);
      #1;
      s = t - LAT + 1;
      rwin = 1'b0;
      for (int k = (s < 0 ? 0 : s); k <= t; k++) if (v_r[k]) rwin = 1'b1;
      ev = !rwin && (s >= 0) && v_e[s];
      eo = ev ? v_x[s] : 16'h0000;
      chk($sformatf("out[%0d]", t), {16'h0, out}, {16'h0, eo});
      chk($sformatf("valid[%0d]", t), {31'h0, valid}, {31'h0, ev});
      if (valid === 1'b1)
        chk($sformatf("onehot[%0d]", t), $countones(out), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
